// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// full 2*DATA_LENGTH-bit product held until the next operation completes.
module multiplier #(
  parameter int unsigned DATA_LENGTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       finish_o,
  input  logic [DATA_LENGTH-1:0]     indata_a_i,
  input  logic [DATA_LENGTH-1:0]     indata_b_i,
  output logic [2*DATA_LENGTH-1:0]   outdata_r_o
);

  localparam int unsigned CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [2*DATA_LENGTH-1:0]  a_q, a_d;
  logic [DATA_LENGTH-1:0]    b_q, b_d;
  logic [2*DATA_LENGTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*DATA_LENGTH-1:0]  result_q, result_d;
  logic                      busy_q, busy_d;
  logic                      finish_q, finish_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = 1'b0;
    finish_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = {{DATA_LENGTH{1'b0}}, indata_a_i};
          b_d     = indata_b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Shifting the multiplicand left each step is equivalent to adding a << counter.
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          result_d = acc_d;
          busy_d   = 1'b0;
          finish_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign busy_o      = busy_q;
  assign finish_o    = finish_q;
  assign outdata_r_o = result_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: expected products queued at start,
// popped and compared on finish_o; latency, busy window and hold behaviour checked.
module tb_multiplier;

  localparam int unsigned DL = 64;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            finish;
  logic [DL-1:0]   a_in;
  logic [DL-1:0]   b_in;
  logic [2*DL-1:0] result;

  int total = 0;
  int bad   = 0;

  logic [2*DL-1:0] sb_q[$];
  logic [2*DL-1:0] last_result;

  multiplier #(.DATA_LENGTH(DL)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .finish_o    (finish),
    .indata_a_i  (a_in),
    .indata_b_i  (b_in),
    .outdata_r_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*DL-1:0] obs, input logic [2*DL-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Drives start now, follows the run, checks the result on
  // finish and returns at the negedge right after the DONE cycle.
  task automatic run_op(input string tag, input logic [DL-1:0] a, input logic [DL-1:0] b,
                        input bit interfere);
    int n;
    int busy_cnt;
    logic [2*DL-1:0] exp;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb_q.push_back((2*DL)'(a) * (2*DL)'(b));
    @(negedge clk);
    start    = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (!finish && n < 200) begin
      if (busy) busy_cnt++;
      if (interfere && n == 10) begin
        a_in  = 64'd9;
        b_in  = 64'd9;
        start = 1'b1;
      end
      if (interfere && n == 11) start = 1'b0;
      if (n == 32) check({tag, " hold"}, result, last_result);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, (2*DL)'(n), (2*DL)'(DL + 1));
    check({tag, " busy_cycles"}, (2*DL)'(busy_cnt), (2*DL)'(DL));
    check({tag, " busy_in_done"}, (2*DL)'(busy), '0);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    check({tag, " product"}, result, exp);
    last_result = exp;
    @(negedge clk);
    check({tag, " finish_pulse"}, (2*DL)'(finish), '0);
    check({tag, " idle_after"}, (2*DL)'(busy), '0);
  endtask

  initial begin
    int n;
    int fin_seen;
    rst_n       = 1'b0;
    start       = 1'b0;
    a_in        = '0;
    b_in        = '0;
    last_result = '0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("rst busy", (2*DL)'(busy), '0);
    check("rst finish", (2*DL)'(finish), '0);
    check("rst result", result, '0);
    rst_n = 1'b1;
    fin_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (finish || busy) fin_seen++;
    end
    check("post_rst quiet", (2*DL)'(fin_seen), '0);
    check("post_rst result", result, '0);

    // Directed products
    run_op("basic", 64'h0003_0002_0001_0000, 64'd2, 1'b0);
    check("basic literal", result, 128'h0000_0000_0000_0000_0006_0004_0002_0000);
    run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("max literal", result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_op("zero", 64'd0, 64'h1234, 1'b0);

    // Random back-to-back: each start issued in the cycle after finish
    for (int i = 0; i < 100; i++) begin
      logic [DL-1:0] ra;
      logic [DL-1:0] rb;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      run_op("rand", ra, rb, 1'b0);
    end

    // Operand change and start pulse during RUN are ignored
    run_op("interfere", 64'd5, 64'd7, 1'b1);
    check("interfere literal", result, 128'd35);
    repeat (3) @(negedge clk);
    check("interfere no_restart", (2*DL)'(busy), '0);
    check("interfere stable", result, 128'd35);

    // Reset in the middle of RUN
    a_in  = 64'd11;
    b_in  = 64'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("midrst busy_before", (2*DL)'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", (2*DL)'(busy), '0);
    check("midrst finish", (2*DL)'(finish), '0);
    check("midrst result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    last_result = '0;
    fin_seen = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (finish) fin_seen++;
      n++;
    end
    check("midrst no_finish", (2*DL)'(fin_seen), '0);
    run_op("after_rst", 64'd6, 64'd7, 1'b0);
    check("after_rst literal", result, 128'd42);
    check("scoreboard empty", (2*DL)'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
